// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter
// Shares the single data-memory port between the M-stage CPU access and an
// external requester (loader/debug bridge). The CPU normally wins; a small
// starvation counter forces an external grant after STARVE_LIMIT lost cycles.
// CPU stall is combinational toward the pipeline; the external side gets a
// registered one-cycle ack with registered read data.
module dm_port_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [3:0]        cpu_be,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,

  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [31:0]       ext_addr,
  input  logic [3:0]        ext_be,
  input  logic [31:0]       ext_wdata,
  output logic              ext_ack,
  output logic [31:0]       ext_rdata,

  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,

  output logic [15:0]       stall_cnt
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [3:0]  starve_cnt;
  logic        ack_pend;
  logic        ext_ready;
  logic        starved;
  logic        grant_ext;
  logic        grant_cpu;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [3:0]  sel_be;
  logic [31:0] sel_wdata;
  logic        unused_addr_bits;

  // Arbitration: ext wins when the CPU is idle or ext has been starved long
  // enough; the ack cycle never re-grants ext, and reset suppresses any grant.
  always_comb begin
    ext_ready = ext_req && !ack_pend;
    starved   = (starve_cnt >= STARVE_MAX);
    grant_ext = !reset && ext_ready && (!cpu_req || starved);
    grant_cpu = cpu_req && !grant_ext;
  end

  // Port mux: ext fields only when ext is granted, otherwise (including idle
  // cycles) the CPU fields drive the memory port.
  always_comb begin
    sel_we    = cpu_we;
    sel_addr  = cpu_addr;
    sel_be    = cpu_be;
    sel_wdata = cpu_wdata;
    if (grant_ext) begin
      sel_we    = ext_we;
      sel_addr  = ext_addr;
      sel_be    = ext_be;
      sel_wdata = ext_wdata;
    end
  end

  // Memory-port and pipeline-facing outputs; a write needs a live grant, at
  // least one byte lane and no reset.
  always_comb begin
    mem_addr  = sel_addr[ADDR_W+1:2];
    mem_be    = sel_be;
    mem_wdata = sel_wdata;
    mem_we    = sel_we && (sel_be != 4'b0000) && !reset && (grant_cpu || grant_ext);
    cpu_rdata = mem_rdata;
    cpu_stall = cpu_req && grant_ext;
    ext_ack   = ack_pend;
  end

  // Byte-offset and wrap-around address bits are deliberately ignored.
  assign unused_addr_bits = ^{sel_addr[31:ADDR_W+2], sel_addr[1:0]};

  // Count consecutive cycles a ready ext request lost to the CPU.
  always_ff @(posedge clk) begin
    if (reset || grant_ext || !ext_ready) begin
      starve_cnt <= 4'd0;
    end else if (grant_cpu && !starved) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Ext handshake: ack one cycle after the grant, read data captured at the
  // grant (zero for stores so the bridge always sees a defined value).
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_pend  <= 1'b0;
      ext_rdata <= 32'd0;
    end else begin
      ack_pend <= grant_ext;
      if (grant_ext) begin
        ext_rdata <= ext_we ? 32'd0 : mem_rdata;
      end
    end
  end

  // Saturating count of CPU stall cycles for performance monitoring.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 16'd0;
    end else if (cpu_stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule
